// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop synchroniser, mid-bit sampling and a
// first-word-fall-through byte FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
  parameter int DIVW       = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DIVW-1:0] divisor,
  input  logic            rx,
  input  logic            rd,
  input  logic            clr_err,
  output logic [7:0]      rd_data,
  output logic            rx_valid,
  output logic            rx_full,
  output logic            busy,
  output logic            frame_err,
  output logic            overrun,
  output logic [2:0]      dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q, rxs_prev_q;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic            frame_err_q, frame_err_d, overrun_q, overrun_d;

  logic            fall, cnt_zero, push, ferr_set;
  logic            empty, full, pop, push_ok;
  logic [DIVW-1:0] full_bit, half_bit;

  // Receiver FSM; all mid-bit sampling is timed off the synchronised edge.
  always_comb begin
    fall      = rxs_prev_q & ~rxs_q;
    cnt_zero  = (cnt_q == '0);
    full_bit  = divisor - DIVW'(1);
    half_bit  = (divisor >> 1) - DIVW'(1);
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - DIVW'(1);
    sh_d      = sh_q;
    bit_idx_d = bit_idx_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          cnt_d   = half_bit;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_zero) begin
          if (!rxs_q) begin
            cnt_d     = full_bit;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          sh_d      = {rxs_q, sh_q[7:1]};
          cnt_d     = full_bit;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_zero) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO: a full FIFO still accepts a push when the head is popped alongside.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
               (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    pop      = rd && !empty;
    push_ok  = push && (!full || rd);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q[PW-2:0]] = sh_q;
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    frame_err_d = ferr_set | (frame_err_q & ~clr_err);
    overrun_d   = (push & ~push_ok) | (overrun_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      bit_idx_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      bit_idx_q   <= bit_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data   = mem_q[rd_ptr_q[PW-2:0]];
  assign rx_valid  = !empty;
  assign rx_full   = full;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver for the vc32 CPU. Deserialises the asynchronous 8N1 serial input into bytes, buffers them in a small first-word-fall-through FIFO, and reports framing and overrun errors to the CPU's peripheral register logic. It is the receive counterpart of the CPU's UART transmit pin and uses the same bit-timing convention, with LSB first.

## Interface
- `DIVW`, default 16: width of the bit-period divisor.
- `DEPTH_LOG2`, default 2: log2 of the FIFO depth; default depth is 4 entries.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `divisor` input, `DIVW` bits: bit period in `clk` cycles; the minimum legal value is 4. Change it only while `busy` is 0.
- `rx` input, 1 bit: raw serial line, idle high, asynchronous to `clk`.
- `rd` input, 1 bit: pop the FIFO head this cycle; ignored when the FIFO is empty.
- `clr_err` input, 1 bit: clears `frame_err` and `overrun`.
- `rd_data` output, 8 bits: FIFO head, valid while `rx_valid` is high.
- `rx_valid` output, 1 bit: FIFO not empty.
- `rx_full` output, 1 bit: FIFO full.
- `busy` output, 1 bit: receiver state is not IDLE.
- `frame_err` output, 1 bit: sticky; set when a stop bit is sampled as 0.
- `overrun` output, 1 bit: sticky; set when a byte is dropped because the FIFO is full.

## Operation
- **Synchroniser**
  - `rx` passes through two flops, both reset to 1, giving `rxs`.
  - A falling edge is detected when the previous `rxs` was 1 and the current `rxs` is 0.
- **Bit counter `cnt`** (`DIVW` bits)
  - Loaded with a value, decrements once per cycle.
  - Acts in the cycle where `cnt == 0`.
  - Load `divisor-1` for a full bit; load `(divisor>>1)-1` for the half bit.
- **States**
  - IDLE: on a falling edge, load the half-bit count and go to START.
  - START: at `cnt == 0`, if `rxs == 0` load `divisor-1`, clear the bit index and go to DATA. Otherwise (false start) return to IDLE with nothing pushed.
  - DATA: at `cnt == 0`, shift `sh <= {rxs, sh[7:1]}` and reload `divisor-1`. After the 8th bit, go to STOP.
  - STOP: at `cnt == 0`:
    - If `rxs == 1`, push `sh` and go to IDLE.
    - If `rxs == 0`, set `frame_err`, push nothing and go to BREAK.
  - BREAK: wait for `rxs == 1`, then go to IDLE. A held-low line therefore yields exactly one framing error and no bytes.
- **FIFO**
  - `2**DEPTH_LOG2` entries, first-word-fall-through; `rd_data` is driven from the read pointer with no added latency.
  - The pointers are `DEPTH_LOG2+1` bits wide and wrap naturally. Full is defined as the MSBs differing and the remaining bits equal.
  - A push is accepted when not full, or when full and `rd` is asserted in the same cycle; the pop takes effect and the new byte is stored.
  - A push that is refused sets `overrun` and discards the byte. The existing contents are preserved.
  - Pop and push in the same cycle while empty: the push is stored and the pop is ignored.
- **Error flags**
  - `clr_err` clears both sticky flags.
  - If `clr_err` and a set event occur in the same cycle, set wins.
- **Reset** (asynchronous, any time including mid-frame)
  - State returns to IDLE; `cnt`, `sh` and both pointers clear.
  - Outputs after reset: `rd_data = 0x00`, `rx_valid = 0`, `rx_full = 0`, `busy = 0`, `frame_err = 0`, `overrun = 0`.
  - Synchroniser flops reset to 1, so a line that is low at reset release is seen as a falling edge.

## Timing
- `rxs` lags `rx` by 2 cycles.
- Let cycle E be the cycle in which the falling edge is detected on `rxs`, and let D = `divisor`:
  - Start check at E + D/2 (integer halving).
  - Data bit k (k = 0..7) sampled at E + D/2 + (k+1)·D.
  - Stop bit sampled at E + D/2 + 9·D.
  - `rx_valid` rises one cycle after the stop sample.
- A new falling edge is accepted in the cycle after the stop sample, so back-to-back frames with one stop bit are supported.
- `busy` is high from E+1 until the cycle after the stop sample, or until BREAK exits.
- A pop is registered: after `rd` in cycle N, `rd_data` shows the next entry in cycle N+1.
- Sticky flags rise one cycle after the causing sample.

## Test plan
- **Single byte:** `divisor = 8`, send 0x55 as 8N1 at 8 clocks per bit → `rx_valid` rises 1 cycle after the stop sample, `rd_data = 0x55`. Pulse `rd` → `rx_valid = 0`, no error flags.
- **False start:** drive `rx` low for 3 cycles with `divisor = 16` → no push, `busy` returns to 0, flags stay 0.
- **Framing error:** send 0xA3 with the stop bit at 0, then return the line high → `frame_err = 1`, FIFO empty. A following 0x3C is received correctly. `clr_err` → `frame_err = 0`.
- **Overrun:** send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads → `rx_full = 1` after the 4th byte and `overrun = 1` after the 5th. Draining yields 0x01–0x04 in order.
- **Full plus simultaneous pop:** with the FIFO full, assert `rd` in the cycle the 5th byte pushes → no overrun. Draining yields 0x02, 0x03, 0x04, 0x05.
- **Reset mid-frame:** assert `rst_n = 0` during data bit 4 → all outputs are 0 immediately. After release, the next full frame 0xFF is received correctly.
